alu_pipe: RTL and testbench

Parametrised, handshaked successor to the team's single-issue ALU. It accepts one operation per transaction over a valid/ready input port and returns the result over a valid/ready output port with backpressure. Logic and arithmetic operations complete in one cycle. The two multiply operations run on a multi-cycle path of configurable latency. It sits between the command scheduler and the writeback stage, and results always complete in issue order.

---
 rtl/alu_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arithmetic ops plus a multi-cycle multiply path.
// One request in flight or held at a time, so results always leave in issue order.
module alu_pipe #(
  parameter int W       = 8,
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [3:0]         cmd,
  input  logic [1:0]         inp_valid,
  input  logic               cin,
  input  logic [W-1:0]       opa,
  input  logic [W-1:0]       opb,
  input  logic [TAG_W-1:0]   tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     res,
  output logic [TAG_W-1:0]   out_tag,
  output logic               cout,
  output logic               ov,
  output logic               g,
  output logic               l,
  output logic               e,
  output logic               err
);

  // state | meaning
  // IDLE  | no multiply in flight; requests accepted when output can take a result
  // MUL   | multiply in flight; cnt counts down to the completion edge

  localparam int SH_W  = $clog2(W);
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [W:0]       ONE1     = (W+1)'(1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W:0]       mul_a, mul_b;
  logic [TAG_W-1:0] mul_tag;
  logic [2*W-1:0]   prod;
  logic             accept;

  logic [W:0]       ext_a, ext_b, cin_w;
  logic [W:0]       add_r, addc_r, sub_r, subc_r, inca_r, deca_r, incb_r, decb_r;
  logic [W-1:0]     s_add_r, s_sub_r, rol_r, ror_r;
  logic             s_add_ov, s_sub_ov, s_gt, s_lt;
  logic [SH_W-1:0]  amt;
  logic [SH_W:0]    amt_inv;
  logic             rot_bad;

  logic             need_a, need_b, known, c_rot;
  logic [2*W-1:0]   c_res;
  logic             c_cout, c_ov, c_g, c_l, c_e, c_err, c_mul;
  logic [W:0]       c_ma, c_mb;

  assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign ext_a  = {1'b0, opa};
  assign ext_b  = {1'b0, opb};
  assign cin_w  = {{W{1'b0}}, cin};
  assign add_r  = ext_a + ext_b;
  assign addc_r = ext_a + ext_b + cin_w;
  assign sub_r  = ext_a - ext_b;
  assign subc_r = ext_a - ext_b - cin_w;
  assign inca_r = ext_a + ONE1;
  assign deca_r = ext_a - ONE1;
  assign incb_r = ext_b + ONE1;
  assign decb_r = ext_b - ONE1;

  assign s_add_r  = opa + opb;
  assign s_sub_r  = opa - opb;
  assign s_add_ov = (opa[W-1] == opb[W-1]) && (s_add_r[W-1] != opa[W-1]);
  assign s_sub_ov = (opa[W-1] != opb[W-1]) && (s_sub_r[W-1] != opa[W-1]);
  assign s_gt     = $signed(opa) > $signed(opb);
  assign s_lt     = $signed(opa) < $signed(opb);

  // Shifting by the full width yields zero, so amount 0 returns A unchanged.
  assign amt     = opb[SH_W-1:0];
  assign amt_inv = (SH_W+1)'(W) - {1'b0, amt};
  assign rol_r   = (opa << amt) | (opa >> amt_inv);
  assign ror_r   = (opa >> amt) | (opa << amt_inv);
  assign rot_bad = |opb[W-1:SH_W];

  // Truncated product: only the low 2W bits are ever needed.
  assign prod = {{(W-1){1'b0}}, mul_a} * {{(W-1){1'b0}}, mul_b};

  always_comb begin
    need_a = 1'b0;
    need_b = 1'b0;
    known  = 1'b1;
    c_rot  = 1'b0;
    c_res  = '0;
    c_cout = 1'b0;
    c_ov   = 1'b0;
    c_g    = 1'b0;
    c_l    = 1'b0;
    c_e    = 1'b0;
    c_err  = 1'b0;
    c_mul  = 1'b0;
    c_ma   = '0;
    c_mb   = '0;
    if (mode) begin
      case (cmd)
        4'd0:  begin need_a = 1'b1; need_b = 1'b1;
                 c_res = {{(W-1){1'b0}}, add_r};  c_cout = add_r[W];  end
        4'd1:  begin need_a = 1'b1; need_b = 1'b1;
                 c_res = {{(W-1){1'b0}}, sub_r};  c_ov = sub_r[W];    end
        4'd2:  begin need_a = 1'b1; need_b = 1'b1;
                 c_res = {{(W-1){1'b0}}, addc_r}; c_cout = addc_r[W]; end
        4'd3:  begin need_a = 1'b1; need_b = 1'b1;
                 c_res = {{(W-1){1'b0}}, subc_r}; c_ov = subc_r[W];   end
        4'd4:  begin need_a = 1'b1;
                 c_res = {{(W-1){1'b0}}, inca_r}; c_cout = inca_r[W]; end
        4'd5:  begin need_a = 1'b1;
                 c_res = {{(W-1){1'b0}}, deca_r}; c_ov = deca_r[W];   end
        4'd6:  begin need_b = 1'b1;
                 c_res = {{(W-1){1'b0}}, incb_r}; c_cout = incb_r[W]; end
        4'd7:  begin need_b = 1'b1;
                 c_res = {{(W-1){1'b0}}, decb_r}; c_ov = decb_r[W];   end
        4'd8:  begin need_a = 1'b1; need_b = 1'b1;
                 c_g = opa > opb; c_l = opa < opb; c_e = opa == opb; end
        4'd9:  begin need_a = 1'b1; need_b = 1'b1; c_mul = 1'b1;
                 c_ma = inca_r; c_mb = incb_r; end
        4'd10: begin need_a = 1'b1; need_b = 1'b1; c_mul = 1'b1;
                 c_ma = {opa, 1'b0}; c_mb = ext_b; end
        4'd11: begin need_a = 1'b1; need_b = 1'b1;
                 c_res = {{W{s_add_r[W-1]}}, s_add_r}; c_ov = s_add_ov;
                 c_g = s_gt; c_l = s_lt; c_e = opa == opb; end
        4'd12: begin need_a = 1'b1; need_b = 1'b1;
                 c_res = {{W{s_sub_r[W-1]}}, s_sub_r}; c_ov = s_sub_ov;
                 c_g = s_gt; c_l = s_lt; c_e = opa == opb; end
        default: known = 1'b0;
      endcase
    end else begin
      case (cmd)
        4'd0:  begin need_a = 1'b1; need_b = 1'b1; c_res = {{W{1'b0}}, opa & opb};    end
        4'd1:  begin need_a = 1'b1; need_b = 1'b1; c_res = {{W{1'b0}}, ~(opa & opb)}; end
        4'd2:  begin need_a = 1'b1; need_b = 1'b1; c_res = {{W{1'b0}}, opa | opb};    end
        4'd3:  begin need_a = 1'b1; need_b = 1'b1; c_res = {{W{1'b0}}, ~(opa | opb)}; end
        4'd4:  begin need_a = 1'b1; need_b = 1'b1; c_res = {{W{1'b0}}, opa ^ opb};    end
        4'd5:  begin need_a = 1'b1; need_b = 1'b1; c_res = {{W{1'b0}}, ~(opa ^ opb)}; end
        4'd6:  begin need_a = 1'b1; c_res = {{W{1'b0}}, ~opa};                 end
        4'd7:  begin need_b = 1'b1; c_res = {{W{1'b0}}, ~opb};                 end
        4'd8:  begin need_a = 1'b1; c_res = {{W{1'b0}}, 1'b0, opa[W-1:1]};     end
        4'd9:  begin need_a = 1'b1; c_res = {{W{1'b0}}, opa[W-2:0], 1'b0};     end
        4'd10: begin need_b = 1'b1; c_res = {{W{1'b0}}, 1'b0, opb[W-1:1]};     end
        4'd11: begin need_b = 1'b1; c_res = {{W{1'b0}}, opb[W-2:0], 1'b0};     end
        4'd12: begin need_a = 1'b1; need_b = 1'b1; c_rot = 1'b1;
                 c_res = {{W{1'b0}}, rol_r}; end
        4'd13: begin need_a = 1'b1; need_b = 1'b1; c_rot = 1'b1;
                 c_res = {{W{1'b0}}, ror_r}; end
        default: known = 1'b0;
      endcase
    end
    // Any error collapses to the single-cycle path with only err set.
    if (!known || (need_a && !inp_valid[0]) || (need_b && !inp_valid[1]) ||
        (c_rot && rot_bad)) begin
      c_res  = '0;
      c_cout = 1'b0;
      c_ov   = 1'b0;
      c_g    = 1'b0;
      c_l    = 1'b0;
      c_e    = 1'b0;
      c_err  = 1'b1;
      c_mul  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_tag   <= '0;
      out_valid <= 1'b0;
      res       <= '0;
      out_tag   <= '0;
      cout      <= 1'b0;
      ov        <= 1'b0;
      g         <= 1'b0;
      l         <= 1'b0;
      e         <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && c_mul) begin
            state   <= MUL;
            cnt     <= CNT_LOAD;
            mul_a   <= c_ma;
            mul_b   <= c_mb;
            mul_tag <= tag;
          end
        end
        MUL: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (accept && !c_mul) begin
        out_valid <= 1'b1;
        res       <= c_res;
        out_tag   <= tag;
        cout      <= c_cout;
        ov        <= c_ov;
        g         <= c_g;
        l         <= c_l;
        e         <= c_e;
        err       <= c_err;
      end else if (state == MUL && cnt == '0) begin
        // Output register is guaranteed empty here: accepting a multiply drained it.
        out_valid <= 1'b1;
        res       <= prod;
        out_tag   <= mul_tag;
        cout      <= 1'b0;
        ov        <= 1'b0;
        g         <= 1'b0;
        l         <= 1'b0;
        e         <= 1'b0;
        err       <= 1'b0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (W=8, MUL_LAT=3, TAG_W=4).
module tb_alu_pipe;

  localparam int LAT = 3;

  logic        clk, rst, in_valid, in_ready, mode, cin;
  logic [3:0]  cmd, tag, out_tag;
  logic [1:0]  inp_valid;
  logic [7:0]  opa, opb;
  logic        out_valid, out_ready;
  logic [15:0] res;
  logic        cout, ov, g, l, e, err;

  int n_vec  = 0;
  int n_miss = 0;

  alu_pipe #(.W(8), .MUL_LAT(LAT), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .cmd(cmd), .inp_valid(inp_valid), .cin(cin),
    .opa(opa), .opb(opb), .tag(tag), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .out_tag(out_tag),
    .cout(cout), .ov(ov), .g(g), .l(l), .e(e), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Presents a request and returns 1 time unit after the edge that accepts it.
  task automatic send(input logic m, input logic [3:0] c, input logic [1:0] iv,
                      input logic ci, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] t);
    logic ok;
    mode = m; cmd = c; inp_valid = iv; cin = ci; opa = a; opb = b; tag = t;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic run_vec(input string nm, input logic m, input logic [3:0] c,
                         input logic [1:0] iv, input logic ci, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp_res,
                         input logic [5:0] exp_flags, input logic [3:0] t);
    send(m, c, iv, ci, a, b, t);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_res"}, res, exp_res);
    chk({nm, "_flags"}, {cout, ov, g, l, e, err}, exp_flags);
    chk({nm, "_tag"}, out_tag, t);
  endtask

  task automatic mul_vec(input string nm, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp_res,
                         input logic [3:0] t);
    int cyc;
    send(1'b1, c, 2'b11, 1'b0, a, b, t);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      chk({nm, "_busy_ready"}, in_ready, 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({nm, "_latency"}, cyc, LAT);
    chk({nm, "_res"}, res, exp_res);
    chk({nm, "_flags"}, {cout, ov, g, l, e, err}, 6'b0);
    chk({nm, "_tag"}, out_tag, t);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0; cmd = '0;
    inp_valid = '0; cin = 1'b0; opa = '0; opb = '0; tag = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_flags", {cout, ov, g, l, e, err}, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // flags order: {cout, ov, g, l, e, err}
    run_vec("add",      1, 4'd0,  2'b11, 0, 8'hFF, 8'h01, 16'h0100, 6'b100000, 4'd5);
    run_vec("sub",      1, 4'd1,  2'b11, 0, 8'h05, 8'h07, 16'h01FE, 6'b010000, 4'd6);
    run_vec("add_cin",  1, 4'd2,  2'b11, 1, 8'h10, 8'h20, 16'h0031, 6'b000000, 4'd7);
    run_vec("sub_cin",  1, 4'd3,  2'b11, 1, 8'h20, 8'h10, 16'h000F, 6'b000000, 4'd8);
    run_vec("inc_a",    1, 4'd4,  2'b01, 0, 8'hFF, 8'h00, 16'h0100, 6'b100000, 4'd9);
    run_vec("dec_a",    1, 4'd5,  2'b01, 0, 8'h01, 8'h00, 16'h0000, 6'b000000, 4'd10);
    run_vec("inc_b",    1, 4'd6,  2'b10, 0, 8'h00, 8'h7F, 16'h0080, 6'b000000, 4'd11);
    run_vec("dec_b",    1, 4'd7,  2'b10, 0, 8'h00, 8'h00, 16'h01FF, 6'b010000, 4'd12);
    run_vec("cmp_gt",   1, 4'd8,  2'b11, 0, 8'h05, 8'h03, 16'h0000, 6'b001000, 4'd13);
    run_vec("cmp_eq",   1, 4'd8,  2'b11, 0, 8'h03, 8'h03, 16'h0000, 6'b000010, 4'd14);
    run_vec("cmp_lt",   1, 4'd8,  2'b11, 0, 8'h02, 8'h09, 16'h0000, 6'b000100, 4'd15);
    run_vec("s_add_ov", 1, 4'd11, 2'b11, 0, 8'h7F, 8'h01, 16'hFF80, 6'b011000, 4'd1);
    run_vec("s_add_neg",1, 4'd11, 2'b11, 0, 8'hFF, 8'hFF, 16'hFFFE, 6'b000010, 4'd2);
    run_vec("s_sub_ov", 1, 4'd12, 2'b11, 0, 8'h80, 8'h01, 16'h007F, 6'b010100, 4'd3);
    run_vec("and",      0, 4'd0,  2'b11, 0, 8'hF0, 8'h3C, 16'h0030, 6'b000000, 4'd4);
    run_vec("nand",     0, 4'd1,  2'b11, 0, 8'hF0, 8'h3C, 16'h00CF, 6'b000000, 4'd5);
    run_vec("or",       0, 4'd2,  2'b11, 0, 8'hF0, 8'h0F, 16'h00FF, 6'b000000, 4'd6);
    run_vec("nor",      0, 4'd3,  2'b11, 0, 8'hF0, 8'h0F, 16'h0000, 6'b000000, 4'd7);
    run_vec("xor",      0, 4'd4,  2'b11, 0, 8'hAA, 8'h0F, 16'h00A5, 6'b000000, 4'd8);
    run_vec("xnor",     0, 4'd5,  2'b11, 0, 8'hAA, 8'h0F, 16'h005A, 6'b000000, 4'd9);
    run_vec("not_a",    0, 4'd6,  2'b01, 0, 8'h0F, 8'h00, 16'h00F0, 6'b000000, 4'd10);
    run_vec("not_b",    0, 4'd7,  2'b10, 0, 8'h00, 8'h3C, 16'h00C3, 6'b000000, 4'd11);
    run_vec("shr1_a",   0, 4'd8,  2'b01, 0, 8'h81, 8'h00, 16'h0040, 6'b000000, 4'd12);
    run_vec("shl1_a",   0, 4'd9,  2'b01, 0, 8'h81, 8'h00, 16'h0002, 6'b000000, 4'd13);
    run_vec("shr1_b",   0, 4'd10, 2'b10, 0, 8'h00, 8'h81, 16'h0040, 6'b000000, 4'd14);
    run_vec("shl1_b",   0, 4'd11, 2'b10, 0, 8'h00, 8'h81, 16'h0002, 6'b000000, 4'd15);
    run_vec("rol_1",    0, 4'd12, 2'b11, 0, 8'h81, 8'h01, 16'h0003, 6'b000000, 4'd1);
    run_vec("rol_0",    0, 4'd12, 2'b11, 0, 8'h81, 8'h00, 16'h0081, 6'b000000, 4'd2);
    run_vec("rol_7",    0, 4'd12, 2'b11, 0, 8'h81, 8'h07, 16'h00C0, 6'b000000, 4'd3);
    run_vec("ror_1",    0, 4'd13, 2'b11, 0, 8'h81, 8'h01, 16'h00C0, 6'b000000, 4'd4);
    run_vec("ror_bad",  0, 4'd13, 2'b11, 0, 8'h81, 8'h10, 16'h0000, 6'b000001, 4'd5);
    run_vec("rol_bad",  0, 4'd12, 2'b11, 0, 8'h81, 8'h08, 16'h0000, 6'b000001, 4'd6);
    run_vec("sub_noB",  1, 4'd1,  2'b01, 0, 8'h05, 8'h01, 16'h0000, 6'b000001, 4'd7);
    run_vec("not_a_noA",0, 4'd6,  2'b10, 0, 8'h05, 8'h01, 16'h0000, 6'b000001, 4'd8);
    run_vec("add_none", 1, 4'd0,  2'b00, 0, 8'h05, 8'h01, 16'h0000, 6'b000001, 4'd9);
    run_vec("arith_13", 1, 4'd13, 2'b11, 0, 8'h05, 8'h01, 16'h0000, 6'b000001, 4'd10);
    run_vec("logic_15", 0, 4'd15, 2'b11, 0, 8'h05, 8'h01, 16'h0000, 6'b000001, 4'd11);
    run_vec("mul_noB",  1, 4'd9,  2'b01, 0, 8'h03, 8'h04, 16'h0000, 6'b000001, 4'd12);

    mul_vec("mult_inc",   4'd9,  8'h03, 8'h04, 16'h0014, 4'd7);
    mul_vec("mult_inc_ff",4'd9,  8'hFF, 8'hFF, 16'h0000, 4'd8);
    mul_vec("mult_shl",   4'd10, 8'h80, 8'h03, 16'h0300, 4'd9);
    mul_vec("mult_shl2",  4'd10, 8'h12, 8'h10, 16'h0240, 4'd10);

    // Backpressure: the second request stalls while the first result is held.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(1'b1, 4'd0, 2'b11, 1'b0, 8'h01, 8'h01, 4'd1);
    mode = 1'b1; cmd = 4'd0; inp_valid = 2'b11; cin = 1'b0;
    opa = 8'h02; opb = 8'h02; tag = 4'd2; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_tag", out_tag, 1);
      chk("bp_hold_res", res, 16'h0002);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_tag", out_tag, 2);
    chk("bp_second_res", res, 16'h0004);
    @(posedge clk);
    #1;
    chk("bp_drained", out_valid, 0);

    // Reset while a multiply is in flight abandons it.
    send(1'b1, 4'd9, 2'b11, 1'b0, 8'h03, 8'h04, 4'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    chk("midrst_no_late", seen, 0);
    run_vec("post_rst_add", 1, 4'd0, 2'b11, 0, 8'h02, 8'h03, 16'h0005, 6'b000000, 4'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
